// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encodings, latched frame format, parity helper.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Frame format captured at the start of each frame
  typedef struct packed {
    logic [1:0] bits;     // data bits = 5 + bits
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } uart_cfg_t;

  // Index of the last data bit for a given frame width (4..7)
  function automatic logic [2:0] last_idx(input logic [1:0] bits);
    return 3'd4 + {1'b0, bits};
  endfunction

  // Parity over the active data bits only; odd parity inverts the XOR
  function automatic logic par_calc(input logic [7:0] dat, input logic [1:0] bits,
                                    input logic odd);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - bits);
    return (^(dat & mask)) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB wrap pointers.
// Latency: a pushed entry is visible on pop_dat_o the cycle after the push.
// Backpressure: push is taken when not full, or when full with a pop in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_rdy_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             push_en;
  logic             pop_en;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en    = pop_rdy_i && !empty;
  assign push_en   = push_vld_i && (!full_o || pop_en);
  assign pop_vld_o = !empty;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance each pointer independently; simultaneous push/pop keeps the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with runtime frame format, oversampled RX and per-direction FIFOs.
// Latency: tx falls 2 clocks after a byte enters an idle TX path; RX byte is readable the clock after its stop sample.
// Backpressure: tx_ready drops when the TX FIFO is full; RX bytes arriving on a full FIFO are dropped and flagged.
module uart_fifo_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic             tx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_bits,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             cfg_stop2,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_overrun,
  input  logic             err_clr,
  output logic             tx_busy,
  output logic             rx_busy
);
  import uart_pkg::*;

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  uart_cfg_t cur_cfg;
  assign cur_cfg = {cfg_bits, cfg_par_en, cfg_par_odd, cfg_stop2};

  // ---------------- TX path ----------------
  tx_state_e        tx_st_q, tx_st_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d;
  logic [OS_W-1:0]  tx_os_q, tx_os_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  uart_cfg_t        tx_cfg_q, tx_cfg_d;
  logic             tx_q, tx_d;
  logic             tx_tick, tx_bit_end, tx_pop;
  logic             tx_fifo_vld, tx_fifo_full;
  logic [7:0]       tx_fifo_dat;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (tx_valid && tx_ready),
    .push_dat_i (tx_data),
    .pop_rdy_i  (tx_pop),
    .pop_vld_o  (tx_fifo_vld),
    .pop_dat_o  (tx_fifo_dat),
    .full_o     (tx_fifo_full)
  );

  assign tx_ready   = !tx_fifo_full;
  assign tx_tick    = (tx_div_q == '0);
  assign tx_bit_end = tx_tick && (tx_os_q == OS_LAST);
  assign tx_div_d   = (tx_tick || tx_pop) ? baud_div : tx_div_q - DIV_W'(1);
  assign tx         = tx_q;
  assign tx_busy    = (tx_st_q != TX_IDLE);

  // TX next state: serialise start/data/parity/stop; chain the next byte straight out of STOP
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_os_d  = tx_os_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    tx_cfg_d = tx_cfg_q;
    tx_pop   = 1'b0;
    tx_d     = 1'b1;
    if (tx_tick) tx_os_d = tx_bit_end ? '0 : tx_os_q + OS_W'(1);
    case (tx_st_q)
      TX_IDLE: begin
        if (tx_fifo_vld) tx_pop = 1'b1;
      end
      TX_START: begin
        tx_d = 1'b0;
        if (tx_bit_end) begin
          tx_st_d  = TX_DATA;
          tx_idx_d = '0;
        end
      end
      TX_DATA: begin
        tx_d = tx_sh_q[tx_idx_q];
        if (tx_bit_end) begin
          if (tx_idx_q == last_idx(tx_cfg_q.bits)) begin
            tx_idx_d = '0;
            tx_st_d  = tx_cfg_q.par_en ? TX_PAR : TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end
      end
      TX_PAR: begin
        tx_d = par_calc(tx_sh_q, tx_cfg_q.bits, tx_cfg_q.par_odd);
        if (tx_bit_end) begin
          tx_st_d  = TX_STOP;
          tx_idx_d = '0;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (tx_bit_end) begin
          if (tx_cfg_q.stop2 && (tx_idx_q == 3'd0)) tx_idx_d = 3'd1;
          else if (tx_fifo_vld)                     tx_pop   = 1'b1;
          else                                      tx_st_d  = TX_IDLE;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
    // Frame start: latch byte and format, restart the bit timer
    if (tx_pop) begin
      tx_st_d  = TX_START;
      tx_os_d  = '0;
      tx_idx_d = '0;
      tx_sh_d  = tx_fifo_dat;
      tx_cfg_d = cur_cfg;
    end
  end

  // TX state, divider and registered line driver
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_st_q  <= TX_IDLE;
      tx_div_q <= baud_div;
      tx_os_q  <= '0;
      tx_idx_q <= '0;
      tx_sh_q  <= '0;
      tx_cfg_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_div_q <= tx_div_d;
      tx_os_q  <= tx_os_d;
      tx_idx_q <= tx_idx_d;
      tx_sh_q  <= tx_sh_d;
      tx_cfg_q <= tx_cfg_d;
      tx_q     <= tx_d;
    end
  end

  // ---------------- RX path ----------------
  rx_state_e        rx_st_q, rx_st_d;
  logic [DIV_W-1:0] rx_div_q, rx_div_d;
  logic [OS_W-1:0]  rx_os_q, rx_os_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_par_q, rx_par_d;
  logic [1:0]       rx_bits_q, rx_bits_d;
  logic             rx_pen_q, rx_pen_d;
  logic             rx_podd_q, rx_podd_d;
  logic             rx_s1_q, rx_s2_q;
  logic             rx_ovr_q;
  logic             rx_tick, rx_bit_end, rx_start, rx_push;
  logic             rx_ferr_bit, rx_perr_bit;
  logic             rx_fifo_full, rx_drop;
  logic [9:0]       rx_fifo_dat;

  uart_sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (rx_push),
    .push_dat_i ({rx_ferr_bit, rx_perr_bit, rx_sh_q}),
    .pop_rdy_i  (rx_ready),
    .pop_vld_o  (rx_valid),
    .pop_dat_o  (rx_fifo_dat),
    .full_o     (rx_fifo_full)
  );

  assign rx_data     = rx_fifo_dat[7:0];
  assign rx_perr     = rx_fifo_dat[8];
  assign rx_ferr     = rx_fifo_dat[9];
  assign rx_overrun  = rx_ovr_q;
  assign rx_busy     = (rx_st_q != RX_IDLE);
  assign rx_tick     = (rx_div_q == '0);
  assign rx_bit_end  = rx_tick && (rx_os_q == OS_LAST);
  assign rx_div_d    = (rx_tick || rx_start) ? baud_div : rx_div_q - DIV_W'(1);
  assign rx_ferr_bit = !rx_s2_q;
  assign rx_perr_bit = rx_pen_q && (rx_par_q != par_calc(rx_sh_q, rx_bits_q, rx_podd_q));
  assign rx_drop     = rx_push && rx_fifo_full && !(rx_valid && rx_ready);

  // RX next state: qualify start at mid-bit, then sample each bit centre
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_os_d   = rx_os_q;
    rx_idx_d  = rx_idx_q;
    rx_sh_d   = rx_sh_q;
    rx_par_d  = rx_par_q;
    rx_bits_d = rx_bits_q;
    rx_pen_d  = rx_pen_q;
    rx_podd_d = rx_podd_q;
    rx_start  = 1'b0;
    rx_push   = 1'b0;
    if (rx_tick) rx_os_d = rx_bit_end ? '0 : rx_os_q + OS_W'(1);
    case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_start  = 1'b1;
          rx_st_d   = RX_START;
          rx_os_d   = '0;
          rx_idx_d  = '0;
          rx_sh_d   = '0;
          rx_bits_d = cfg_bits;
          rx_pen_d  = cfg_par_en;
          rx_podd_d = cfg_par_odd;
        end
      end
      RX_START: begin
        if (rx_tick && (rx_os_q == OS_HALF)) begin
          rx_os_d = '0;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_sh_d[rx_idx_q] = rx_s2_q;
          if (rx_idx_q == last_idx(rx_bits_q)) begin
            rx_idx_d = '0;
            rx_st_d  = rx_pen_q ? RX_PAR : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end
      end
      RX_PAR: begin
        if (rx_bit_end) begin
          rx_par_d = rx_s2_q;
          rx_st_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_push = 1'b1;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rx_s2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // RX synchroniser, state and divider
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_div_q  <= baud_div;
      rx_os_q   <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_par_q  <= 1'b0;
      rx_bits_q <= '0;
      rx_pen_q  <= 1'b0;
      rx_podd_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_st_q   <= rx_st_d;
      rx_div_q  <= rx_div_d;
      rx_os_q   <= rx_os_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      rx_par_q  <= rx_par_d;
      rx_bits_q <= rx_bits_d;
      rx_pen_q  <= rx_pen_d;
      rx_podd_q <= rx_podd_d;
    end
  end

  // Sticky overrun flag; a new drop beats a clear in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n)       rx_ovr_q <= 1'b0;
    else if (rx_drop) rx_ovr_q <= 1'b1;
    else if (err_clr) rx_ovr_q <= 1'b0;
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: TX waveform, loopback, injected RX frames, overrun, glitch, reset.
// Latency: checks exact TX start latency and bit boundaries at 64 clocks per bit.
// Backpressure: holds rx_ready low to fill the RX FIFO and force a drop.
module tb_uart_fifo_core;
  localparam int BIT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_drv, loop_en, rx_line;
  logic        tx;
  logic [15:0] baud_div;
  logic [1:0]  cfg_bits;
  logic        cfg_par_en, cfg_par_odd, cfg_stop2;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_overrun, err_clr;
  logic        tx_busy, rx_busy;
  logic [8:0]  frame;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : rx_drv;

  uart_fifo_core #(.OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_line), .tx(tx), .baud_div(baud_div),
    .cfg_bits(cfg_bits), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd),
    .cfg_stop2(cfg_stop2), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_ferr(rx_ferr), .rx_overrun(rx_overrun), .err_clr(err_clr),
    .tx_busy(tx_busy), .rx_busy(rx_busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] dat, input int nbits, input bit par_en,
                            input bit par_bit, input bit stop_bit);
    rx_drv = 1'b0;
    tick(BIT);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = dat[i];
      tick(BIT);
    end
    if (par_en) begin
      rx_drv = par_bit;
      tick(BIT);
    end
    rx_drv = stop_bit;
    tick(BIT);
    rx_drv = 1'b1;
    tick(BIT / 2);
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(rx_valid), 1);
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while (tx_busy !== 1'b0 && n < 3000) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(tx_busy), 0);
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0; baud_div = 16'd3;
    cfg_bits = 2'd3; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;

    // Reset state
    tick(3);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_overrun", 32'(rx_overrun), 0);
    chk("rst_tx_busy", 32'(tx_busy), 0);
    chk("rst_rx_busy", 32'(rx_busy), 0);
    rst_n = 1'b1;
    tick(5);

    // 8N1 0xA5: latency, start edge, bit pattern, busy release
    frame = {1'b1, 8'hA5};
    tx_valid = 1'b1; tx_data = 8'hA5;
    tick(1);
    tx_valid = 1'b0;
    chk("a5_lat0", 32'(tx), 1);
    tick(1);
    chk("a5_lat1", 32'(tx), 1);
    chk("a5_busy", 32'(tx_busy), 1);
    tick(1);
    chk("a5_start", 32'(tx), 0);
    tick(63);
    chk("a5_start_end", 32'(tx), 0);
    tick(1);
    chk("a5_bit0_edge", 32'(tx), 1);
    tick(32);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick(BIT);
      chk($sformatf("a5_bit%0d", k), 32'(tx), 32'(frame[k]));
    end
    tick(30);
    chk("a5_busy_in_stop", 32'(tx_busy), 1);
    tick(1);
    chk("a5_busy_drop", 32'(tx_busy), 0);

    // Loopback 7E2, byte 0xD5 -> 7 data bits 0x55, even parity 0
    loop_en = 1'b1; cfg_bits = 2'd2; cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b1;
    tx_valid = 1'b1; tx_data = 8'hD5;
    tick(1);
    tx_valid = 1'b0;
    tick(2);
    tick(32 + 8 * BIT);
    chk("7e2_parity_bit", 32'(tx), 0);
    tick(BIT);
    chk("7e2_stop1", 32'(tx), 1);
    tick(BIT);
    chk("7e2_stop2", 32'(tx), 1);
    chk("7e2_busy_stop2", 32'(tx_busy), 1);
    wait_rx("7e2_valid");
    chk("7e2_data", 32'(rx_data), 32'h55);
    chk("7e2_perr", 32'(rx_perr), 0);
    chk("7e2_ferr", 32'(rx_ferr), 0);
    pop_rx();
    chk("7e2_popped", 32'(rx_valid), 0);
    wait_tx_idle("7e2_tx_idle");
    loop_en = 1'b0;
    tick(10);

    // 8O1 0x0F: correct odd parity is 1; wrong bit flags perr
    cfg_bits = 2'd3; cfg_par_en = 1'b1; cfg_par_odd = 1'b1; cfg_stop2 = 1'b0;
    send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1);
    wait_rx("8o1_bad_valid");
    chk("8o1_bad_data", 32'(rx_data), 32'h0F);
    chk("8o1_bad_perr", 32'(rx_perr), 1);
    chk("8o1_bad_ferr", 32'(rx_ferr), 0);
    pop_rx();
    send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b1);
    wait_rx("8o1_good_valid");
    chk("8o1_good_perr", 32'(rx_perr), 0);
    pop_rx();

    // Framing error on 0x3C, then a clean frame once the line idles
    cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    wait_rx("ferr_valid");
    chk("ferr_data", 32'(rx_data), 32'h3C);
    chk("ferr_flag", 32'(rx_ferr), 1);
    chk("ferr_perr", 32'(rx_perr), 0);
    pop_rx();
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    wait_rx("after_ferr_valid");
    chk("after_ferr_data", 32'(rx_data), 32'h81);
    chk("after_ferr_ferr", 32'(rx_ferr), 0);
    pop_rx();

    // Overrun: five bytes into a four-entry FIFO with rx_ready low
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 8, 1'b0, 1'b0, 1'b1);
      if (b == 4) chk("ovr_not_yet", 32'(rx_overrun), 0);
    end
    chk("ovr_set", 32'(rx_overrun), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_valid%0d", i), 32'(rx_valid), 1);
      chk($sformatf("ovr_data%0d", i), 32'(rx_data), 32'(i));
      pop_rx();
    end
    chk("ovr_drained", 32'(rx_valid), 0);
    chk("ovr_sticky", 32'(rx_overrun), 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ovr_cleared", 32'(rx_overrun), 0);

    // Glitch: 20-clock low pulse is rejected at the mid-start check
    rx_drv = 1'b0;
    tick(10);
    chk("glitch_busy", 32'(rx_busy), 1);
    tick(10);
    rx_drv = 1'b1;
    tick(200);
    chk("glitch_no_valid", 32'(rx_valid), 0);
    chk("glitch_idle", 32'(rx_busy), 0);
    chk("glitch_no_ovr", 32'(rx_overrun), 0);

    // Reset mid-frame with a second byte queued
    tx_valid = 1'b1; tx_data = 8'h00;
    tick(1);
    tx_data = 8'hFF;
    tick(1);
    tx_valid = 1'b0;
    tick(100);
    chk("midrst_tx_low", 32'(tx), 0);
    chk("midrst_busy", 32'(tx_busy), 1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_tx_high", 32'(tx), 1);
    chk("midrst_busy_off", 32'(tx_busy), 0);
    chk("midrst_tx_ready", 32'(tx_ready), 1);
    rst_n = 1'b1;
    tick(5);
    chk("midrst_fifo_empty", 32'(tx_busy), 0);
    chk("midrst_tx_idle", 32'(tx), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
